// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts a word over valid/ready and shifts it
// out one bit per shift_en strobe, with frame_start/last_bit framing flags.
module piso_serializer #(
   parameter int WIDTH     = 4,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift_en,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             frame_start,
   output logic             last_bit,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [WIDTH-1:0] sreg, sreg_n;
   logic             accept, consume, last_consume;

   // The bit currently on the line always sits at the outgoing end of the shift register.
   function automatic logic head_bit(input logic [WIDTH-1:0] w);
      return LSB_FIRST ? w[0] : w[WIDTH-1];
   endfunction

   assign last_consume = (cnt == CNT_LAST) & shift_en;
   assign load_ready   = (state == IDLE) | last_consume;
   assign accept       = load_valid & load_ready;
   assign consume      = (state == SHIFT) & shift_en;

   // NOTE: combinational next-state uses blocking '=' with every target defaulted first,
   // so no latch is inferred; the register process below uses non-blocking '<=' only.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      sreg_n  = sreg;
      if (accept) begin
         state_n = SHIFT;
         cnt_n   = '0;
         sreg_n  = load_data;
      end else if (consume && last_consume) begin
         state_n = IDLE;
         cnt_n   = '0;
         sreg_n  = '0;
      end else if (consume) begin
         cnt_n   = cnt + CW'(1);
         sreg_n  = LSB_FIRST ? {1'b0, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], 1'b0};
      end
   end

   // Outputs are registered from the next-state values so they line up with state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         sreg         <= '0;
         serial_out   <= 1'b0;
         serial_valid <= 1'b0;
         frame_start  <= 1'b0;
         last_bit     <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         sreg         <= sreg_n;
         serial_out   <= (state_n == SHIFT) & head_bit(sreg_n);
         serial_valid <= (state_n == SHIFT);
         frame_start  <= (state_n == SHIFT) & (cnt_n == '0);
         last_bit     <= (state_n == SHIFT) & (cnt_n == CNT_LAST);
      end
   end

   assign busy = serial_valid;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: LSB-first and MSB-first instances, stalls,
// async reset mid-frame, back-to-back frames and a random loopback to a SIPO model.
module tb_piso_serializer;

   logic clk = 1'b0;
   logic rst_n;

   logic       l_valid, l_ready, l_shift, l_sout, l_sval, l_fs, l_lb, l_busy;
   logic [3:0] l_data;
   logic       m_valid, m_ready, m_shift, m_sout, m_sval, m_fs, m_lb, m_busy;
   logic [3:0] m_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_lsb (
      .clk(clk), .rst_n(rst_n),
      .load_valid(l_valid), .load_ready(l_ready), .load_data(l_data), .shift_en(l_shift),
      .serial_out(l_sout), .serial_valid(l_sval), .frame_start(l_fs), .last_bit(l_lb),
      .busy(l_busy)
   );

   piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_msb (
      .clk(clk), .rst_n(rst_n),
      .load_valid(m_valid), .load_ready(m_ready), .load_data(m_data), .shift_en(m_shift),
      .serial_out(m_sout), .serial_valid(m_sval), .frame_start(m_fs), .last_bit(m_lb),
      .busy(m_busy)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Called away from a rising edge while the LSB instance is idle; returns just after accept.
   task automatic load_lsb(input logic [3:0] d);
      l_data  = d;
      l_valid = 1'b1;
      #1 check("ready_before_accept", l_ready, 1);
      @(posedge clk);
      #1 l_valid = 1'b0;
   endtask

   task automatic check_lsb_idle(input string tag);
      check({tag, "_valid"}, l_sval, 0);
      check({tag, "_out"},   l_sout, 0);
      check({tag, "_flags"}, {l_fs, l_lb, l_busy}, 0);
   endtask

   logic [7:0] w8;
   logic [5:0] se_after;
   logic [3:0] rx;
   logic [3:0] q[$];

   initial begin
      rst_n   = 1'b0;
      l_valid = 1'b0; l_data = '0; l_shift = 1'b1;
      m_valid = 1'b0; m_data = '0; m_shift = 1'b1;

      // Reset state
      @(negedge clk);
      check_lsb_idle("rst");
      check("rst_msb", {m_sout, m_sval, m_fs, m_lb, m_busy}, 0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", l_ready, 1);

      // 1: 4'b1011 LSB first -> 1,1,0,1 then idle
      load_lsb(4'b1011);
      w8 = 8'h0B;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t1_bit", l_sout, w8[i]);
         check("t1_valid", l_sval, 1);
         check("t1_fs", l_fs, i == 0);
         check("t1_lb", l_lb, i == 3);
      end
      @(negedge clk);
      check_lsb_idle("t1_idle");

      // 2: back-to-back 4'hA then 4'h5 with load_valid held
      l_data  = 4'hA;
      l_valid = 1'b1;
      #1 check("t2_ready0", l_ready, 1);
      @(posedge clk);
      #1 l_data = 4'h5;
      w8 = 8'h5A;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("t2_bit", l_sout, w8[i]);
         check("t2_valid", l_sval, 1);
         check("t2_ready", l_ready, (i == 3) || (i == 7));
         check("t2_fs", l_fs, (i == 0) || (i == 4));
         if (i == 3) begin
            @(posedge clk);
            #1 l_valid = 1'b0;
         end
      end
      @(negedge clk);
      check_lsb_idle("t2_idle");

      // 3: 4'b0110 with a two-cycle stall on bit 1 -> 0,1,1,1,1,0
      load_lsb(4'b0110);
      w8       = 8'b0001_1110;
      se_after = 6'b111001;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("t3_bit", l_sout, w8[i]);
         check("t3_fs", l_fs, i == 0);
         check("t3_lb", l_lb, i == 5);
         l_shift = se_after[i];
      end
      l_shift = 1'b1;
      @(negedge clk);
      check_lsb_idle("t3_idle");

      // 4: async reset after two bits, then a clean frame of 4'h9
      load_lsb(4'hF);
      @(negedge clk);
      @(negedge clk);
      check("t4_pre_rst", l_sout, 1);
      #2 rst_n = 1'b0;
      #1 check_lsb_idle("t4_async");
      @(negedge clk);
      check_lsb_idle("t4_held");
      #2 rst_n = 1'b1;
      @(negedge clk);
      load_lsb(4'h9);
      w8 = 8'h09;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t4_bit", l_sout, w8[i]);
         check("t4_valid", l_sval, 1);
      end
      @(negedge clk);
      check_lsb_idle("t4_idle");

      // 5: MSB first 4'b1000, then 4'hF offered mid-frame and sent as the next frame
      m_data  = 4'b1000;
      m_valid = 1'b1;
      #1 check("t5_ready0", m_ready, 1);
      @(posedge clk);
      #1 m_valid = 1'b0;
      w8 = 8'hF1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("t5_bit", m_sout, w8[i]);
         check("t5_valid", m_sval, 1);
         check("t5_ready", m_ready, (i == 3) || (i == 7));
         check("t5_fs", m_fs, (i == 0) || (i == 4));
         check("t5_lb", m_lb, (i == 3) || (i == 7));
         if (i == 0) begin
            m_data  = 4'hF;
            m_valid = 1'b1;
         end
         if (i == 3) begin
            @(posedge clk);
            #1 m_valid = 1'b0;
         end
      end
      @(negedge clk);
      check("t5_idle", {m_sout, m_sval, m_fs, m_lb, m_busy}, 0);

      // 6: random loopback into an LSB-first 4-bit SIPO model
      begin
         int  sent = 0, recvd = 0, cyc = 0, bitcnt = 0;
         bit  acc = 1'b0;
         rx = '0;
         while (recvd < 200 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (!(l_valid && !acc)) begin
               l_valid = (sent < 200) ? ($urandom_range(0, 2) != 0) : 1'b0;
               l_data  = 4'($urandom);
            end
            l_shift = ($urandom_range(0, 3) != 0);
            #1;
            acc = l_valid && l_ready;
            if (acc) begin
               q.push_back(l_data);
               sent++;
            end
            if (l_sval && l_shift) begin
               check("t6_align", l_fs, bitcnt == 0);
               rx = {l_sout, rx[3:1]};
               bitcnt++;
               if (bitcnt == 4) begin
                  bitcnt = 0;
                  recvd++;
                  if (q.size() == 0) check("t6_underflow", 1, 0);
                  else               check("t6_word", rx, q.pop_front());
               end
            end
         end
         l_valid = 1'b0;
         check("t6_count", recvd, 200);
         check("t6_queue_empty", q.size(), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
